// File: rtl/alu_mode_keypad.sv
// rtl/alu_mode_keypad.sv - four-key debounce front end driving the 3-bit ALU op code
// Each key gets its own synchroniser and debounce FSM; the top owns the mode register.

module alu_mode_keypad_debounce #(
  parameter int DEBOUNCE_MAX = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pulse,
  output logic o_held
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Pulse is decoded on the final counting cycle so it lands DEBOUNCE_MAX+2 cycles after the raw edge.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pulse      = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_sync2) begin
          w_next_state = PRESS_WAIT;
          w_next_cnt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_sync2) begin
          w_next_state = RELEASED;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = PRESSED;
          w_next_cnt   = '0;
          w_pulse      = 1'b1;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_next_state = RELEASE_WAIT;
          w_next_cnt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_sync2) begin
          w_next_state = PRESSED;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = RELEASED;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = RELEASED;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign o_pulse = w_pulse;
  assign o_held  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

endmodule

module alu_mode_keypad #(
  parameter int         DEBOUNCE_MAX = 1_000_000,
  parameter int         CNT_W        = 20,
  parameter logic [2:0] BIG_STEP     = 3'd2,
  parameter logic [2:0] SMALL_STEP   = 3'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_big_up,
  input  logic       key_big_down,
  input  logic       key_small_up,
  input  logic       key_small_down,
  output logic       big_up_pulse,
  output logic       big_down_pulse,
  output logic       small_up_pulse,
  output logic       small_down_pulse,
  output logic [2:0] mode,
  output logic [3:0] key_held
);

  logic [3:0] w_keys;
  logic [3:0] w_pulse;
  logic [3:0] w_held;
  logic [2:0] r_mode;
  logic [2:0] w_mode_next;

  assign w_keys = {key_big_up, key_big_down, key_small_up, key_small_down};

  for (genvar g = 0; g < 4; g++) begin : g_key
    alu_mode_keypad_debounce #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key   (w_keys[g]),
      .o_pulse (w_pulse[g]),
      .o_held  (w_held[g])
    );
  end

  // Only the highest-priority coincident pulse steps the mode; the rest are dropped.
  always_comb begin
    w_mode_next = r_mode;
    if (w_pulse[2]) begin
      w_mode_next = r_mode - BIG_STEP;
    end else if (w_pulse[3]) begin
      w_mode_next = r_mode + BIG_STEP;
    end else if (w_pulse[1]) begin
      w_mode_next = r_mode + SMALL_STEP;
    end else if (w_pulse[0]) begin
      w_mode_next = r_mode - SMALL_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 3'd0;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  assign big_up_pulse     = w_pulse[3];
  assign big_down_pulse   = w_pulse[2];
  assign small_up_pulse   = w_pulse[1];
  assign small_down_pulse = w_pulse[0];
  assign mode             = r_mode;
  assign key_held         = w_held;

endmodule

// File: tb/tb_alu_mode_keypad.sv
// tb/tb_alu_mode_keypad.sv - directed and random checks of alu_mode_keypad against a run-length model
// A key is accepted once its synchronised level has been stable for DEBOUNCE_MAX+1 cycles.

module tb_alu_mode_keypad;

  localparam int DM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw;
  logic       big_up_pulse, big_down_pulse, small_up_pulse, small_down_pulse;
  logic [2:0] mode;
  logic [3:0] key_held;
  logic [3:0] dut_pulses;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_mode;
  logic [3:0] m_s1, m_s2, m_last, m_d, m_dn, m_pulse;
  int         m_run [4];

  alu_mode_keypad #(
    .DEBOUNCE_MAX (DM),
    .CNT_W        (3),
    .BIG_STEP     (3'd2),
    .SMALL_STEP   (3'd1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .key_big_up       (raw[3]),
    .key_big_down     (raw[2]),
    .key_small_up     (raw[1]),
    .key_small_down   (raw[0]),
    .big_up_pulse     (big_up_pulse),
    .big_down_pulse   (big_down_pulse),
    .small_up_pulse   (small_up_pulse),
    .small_down_pulse (small_down_pulse),
    .mode             (mode),
    .key_held         (key_held)
  );

  assign dut_pulses = {big_up_pulse, big_down_pulse, small_up_pulse, small_down_pulse};

  always #5 clk = ~clk;

  // p is {big_up, big_down, small_up, small_down}; mode arithmetic wraps modulo 8.
  function automatic logic [2:0] mode_step(input logic [2:0] m, input logic [3:0] p);
    int delta;
    if (p[2])      delta = -2;
    else if (p[3]) delta = 2;
    else if (p[1]) delta = 1;
    else if (p[0]) delta = -1;
    else           delta = 0;
    return 3'((int'(m) + delta + 8) % 8);
  endfunction

  task automatic model_reset();
    exp_mode = 3'd0;
    m_s1 = '0; m_s2 = '0; m_last = '0;
    m_d = '0; m_dn = '0; m_pulse = '0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_mode = mode_step(exp_mode, m_pulse);
      m_d  = m_dn;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int k = 0; k < 4; k++) begin
        if (m_s2[k] == m_last[k]) m_run[k]++;
        else                      m_run[k] = 1;
        m_last[k]  = m_s2[k];
        m_pulse[k] = !m_d[k] && m_s2[k] && (m_run[k] >= DM + 1);
        m_dn[k]    = m_d[k];
        if (m_pulse[k]) m_dn[k] = 1'b1;
        if (m_d[k] && !m_s2[k] && (m_run[k] >= DM + 1)) m_dn[k] = 1'b0;
      end
    end
    #1;
    checks++;
    assert (dut_pulses === m_pulse) else begin
      errors++;
      $error("FAIL pulses got=%b expected=%b", dut_pulses, m_pulse);
    end
    checks++;
    assert (key_held === m_d) else begin
      errors++;
      $error("FAIL key_held got=%b expected=%b", key_held, m_d);
    end
    checks++;
    assert (mode === exp_mode) else begin
      errors++;
      $error("FAIL mode got=%0d expected=%0d", mode, exp_mode);
    end
  endtask

  task automatic press(input int k);
    raw[k] = 1'b1;
    repeat (10) tick();
    raw[k] = 1'b0;
    repeat (10) tick();
  endtask

  int first_tick, pulse_count, bounce_pulses, t_bd, t_su;

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // reset state, idle keys
    repeat (20) tick();
    check("idle_mode", int'(mode), 0);
    check("idle_held", int'(key_held), 0);

    // single press of small_up: pulse on cycle 6, exactly once
    raw[1] = 1'b1;
    first_tick = -1;
    pulse_count = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (small_up_pulse) begin
        pulse_count++;
        if (first_tick < 0) first_tick = n;
      end
    end
    check("small_up_latency", first_tick, 6);
    check("small_up_count", pulse_count, 1);
    check("small_up_mode", int'(mode), 1);
    raw[1] = 1'b0;
    repeat (12) tick();

    // bouncy big_up
    bounce_pulses = 0;
    for (int n = 0; n < 4; n++) begin
      raw[3] = (n % 2 == 0);
      tick();
      if (big_up_pulse) bounce_pulses++;
    end
    raw[3] = 1'b1;
    first_tick = -1;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (big_up_pulse && first_tick < 0) first_tick = n;
    end
    check("bounce_no_pulse", bounce_pulses, 0);
    check("bounce_latency", first_tick, 6);
    check("bounce_mode", int'(mode), 3);
    raw[3] = 1'b0;
    repeat (12) tick();

    // wrap-around
    press(3);
    press(3);
    check("mode_at_7", int'(mode), 7);
    press(1);
    check("wrap_7_plus_1", int'(mode), 0);
    press(1);
    press(2);
    check("wrap_1_minus_2", int'(mode), 7);

    // coincident big_down and small_up: only big_down steps
    raw[2] = 1'b1;
    raw[1] = 1'b1;
    t_bd = -1;
    t_su = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (big_down_pulse && t_bd < 0) t_bd = n;
      if (small_up_pulse && t_su < 0) t_su = n;
    end
    check("coincident_bd_tick", t_bd, 6);
    check("coincident_su_tick", t_su, 6);
    check("coincident_mode", int'(mode), 5);
    raw = '0;
    repeat (12) tick();

    // reset mid-PRESS_WAIT with the key still held
    raw[0] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_mode", int'(mode), 0);
    check("reset_held", int'(key_held), 0);
    rst_n = 1'b1;
    first_tick = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (small_down_pulse && first_tick < 0) first_tick = n;
    end
    check("post_reset_latency", first_tick, 6);
    check("post_reset_mode", int'(mode), 7);
    raw = '0;
    repeat (12) tick();

    // random bouncy activity on all keys
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 5) == 0) raw[k] = ~raw[k];
      end
      tick();
    end
    raw = '0;
    repeat (12) tick();
    check("final_idle_held", int'(key_held), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
